// File: rtl/ram_dev_pkg.sv
// Shared control-pin bit positions for the bridge RAM port and ram_dev.
// No logic here; pin indices and counter width only.
package ram_dev_pkg;

    localparam int RAM_WRITE_PIN = 0;
    localparam int RAM_READ_PIN  = 1;

    localparam int RAM_ACK  = 0;
    localparam int RAM_ERR  = 1;
    localparam int RAM_BUSY = 2;

    localparam int CNT_W = 8;

endpackage

// File: rtl/ram_dev_array.sv
// Single-port word storage: synchronous write, registered read of the presented address.
// Latency 1 cycle for rdata; no backpressure, no reset on contents.
module ram_dev_array #(
    parameter int word_width = 32,
    parameter int depth      = 1024,
    localparam int AW        = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [word_width-1:0] wdata,
    output logic [word_width-1:0] rdata
);

    logic [word_width-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/ram_dev.sv
// Word RAM device on the bridge RAM port: four-phase ctrl/stat handshake, error on bad requests.
// Ack arrives latency cycles after accept and is held until ctrl drops; inputs ignored while busy.
module ram_dev
    import ram_dev_pkg::*;
#(
    parameter int word_width = 32,
    parameter int depth      = 1024,
    parameter int latency    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] ram_ctrl,
    output logic [word_width-1:0] ram_stat,
    input  logic [word_width-1:0] addr,
    input  logic [word_width-1:0] data_in,
    output logic [word_width-1:0] data_out
);

    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [CNT_W-1:0]    LAT_C   = CNT_W'(latency);
    localparam logic [word_width:0] DEPTH_C = (word_width + 1)'(depth);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [word_width-1:0] wdat_q, wdat_d;
    logic [word_width-1:0] stat_q, stat_d;
    logic [word_width-1:0] dout_q, dout_d;

    logic                  req;
    logic                  out_of_range;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [word_width-1:0] mem_rdata;
    logic                  ctrl_unused;

    assign req          = |ram_ctrl[1:0];
    assign out_of_range = {1'b0, addr} >= DEPTH_C;
    assign ctrl_unused  = ^ram_ctrl[word_width-1:2];

    // The array reads the live address in IDLE so the word is ready even when latency is 1.
    assign mem_addr = (state_q == ST_IDLE) ? addr[AW-1:0] : addr_q;

    ram_dev_array #(
        .word_width(word_width),
        .depth     (depth)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(wdat_q),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        stat_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_BUSY;
                    cnt_d   = LAT_C;
                    wr_d    = ram_ctrl[RAM_WRITE_PIN];
                    rd_d    = ram_ctrl[RAM_READ_PIN];
                    err_d   = (&ram_ctrl[1:0]) | out_of_range;
                    addr_d  = addr[AW-1:0];
                    wdat_d  = data_in;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d = ST_ACK;
                    if (!err_q) begin
                        mem_we = wr_q;
                        if (rd_q) begin
                            dout_d = mem_rdata;
                        end
                    end else if (rd_q) begin
                        dout_d = '0;
                    end
                end
            end
            ST_ACK: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        stat_d[RAM_BUSY] = (state_d == ST_BUSY);
        stat_d[RAM_ACK]  = (state_d == ST_ACK);
        stat_d[RAM_ERR]  = (state_d == ST_ACK) & err_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            stat_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            stat_q  <= stat_d;
            dout_q  <= dout_d;
        end
    end

    assign ram_stat = stat_q;
    assign data_out = dout_q;

endmodule
